// File: rtl/audio_pwm_dac.sv
// rtl/audio_pwm_dac.sv - sample FIFO feeding a single-bit PWM audio output
module audio_pwm_dac #(
    parameter int WIDTH      = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int MIDSCALE   = 2 ** (WIDTH - 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              in_sample,
    input  logic                          in_valid,
    input  logic                          clear_counts,
    output logic                          pwm_out,
    output logic                          sample_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underflow_count,
    output logic [15:0]                   overflow_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [WIDTH-1:0] MID        = WIDTH'(MIDSCALE);
    localparam logic [LW-1:0]    FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty;

    logic wrap;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic ovf_inc;
    logic unf_inc;

    // The last cycle of a PWM period is where the next duty is fetched.
    assign wrap  = enable && (cnt == '1);
    assign empty = (fifo_level == '0);
    assign full  = (fifo_level == FULL_LEVEL);

    // Flush wins over everything. A pop frees a slot in the same cycle, so a
    // full FIFO still accepts a push on the wrap cycle; an empty FIFO never
    // bypasses the incoming sample straight into duty.
    assign pop     = wrap && !flush && !empty;
    assign unf_inc = wrap && !flush && empty;
    assign push    = in_valid && !flush && (!full || pop);
    assign ovf_inc = in_valid && !flush && full && !pop;

    // Sample storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_sample;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // PWM period counter, duty register and registered comparator output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            duty        <= MID;
            pwm_out     <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            cnt         <= enable ? cnt + WIDTH'(1) : '0;
            pwm_out     <= enable && (cnt < duty);
            sample_tick <= pop;
            if (flush) begin
                duty <= MID;
            end else if (pop) begin
                duty <= mem[rd_ptr];
            end
        end
    end

    // Saturating error counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_count <= '0;
            overflow_count  <= '0;
        end else if (clear_counts) begin
            underflow_count <= '0;
            overflow_count  <= '0;
        end else begin
            if (unf_inc && (underflow_count != 16'hFFFF)) begin
                underflow_count <= underflow_count + 16'd1;
            end
            if (ovf_inc && (overflow_count != 16'hFFFF)) begin
                overflow_count <= overflow_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/audio_pwm_dac.md
Name: audio_pwm_dac

Overview:
- Output stage directly downstream of the multi-voice wave generator.
- Consumes its 12-bit `wave`/`valid` sample stream and buffers samples in a small FIFO.
- Converts each sample into one PWM period on a single-bit audio pin.
- Exposes FIFO level and saturating under/overflow counters for MMIO status reads.

Parameters:
- WIDTH, 12, sample width and PWM counter width; PWM period = 2^WIDTH cycles.
- FIFO_DEPTH, 8, sample FIFO entries; power of two, >= 2.
- MIDSCALE, 2^(WIDTH-1), duty loaded at reset and on flush.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = PWM runs; 0 = output parked low.
- flush  in  1  single-cycle pulse: empty FIFO, duty <= MIDSCALE.
- in_sample  in  WIDTH  unsigned sample (generator `wave` output).
- in_valid  in  1  sample strobe; no backpressure.
- clear_counts  in  1  pulse: zero both error counters.
- pwm_out  out  1  registered PWM output.
- sample_tick  out  1  one-cycle pulse when a new duty is loaded from the FIFO.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underflow_count  out  16  PWM periods that started with an empty FIFO; saturating.
- overflow_count  out  16  samples dropped because the FIFO was full; saturating.

Behaviour:
- Reset, asynchronous, all state:
  - pwm_out=0, sample_tick=0, fifo_level=0, both counts=0.
  - pwm counter=0, duty=MIDSCALE, FIFO pointers=0.
- Push: in_valid=1 with level<FIFO_DEPTH writes in_sample. With level==FIFO_DEPTH the sample is dropped and overflow_count increments.
- PWM counter: WIDTH bits, increments every cycle while enable=1, wraps 2^WIDTH-1 -> 0. While enable=0 the counter is held at 0.
- Pop event: occurs on the cycle the counter wraps (counter==2^WIDTH-1 and enable=1).
  - FIFO non-empty: duty <= head, head popped, sample_tick=1 next cycle.
  - FIFO empty: duty holds its old value, underflow_count increments, sample_tick stays 0.
- Simultaneous push and pop:
  - When full, both occur: the push is accepted, there is no overflow, and level is unchanged.
  - When empty, the pop sees empty (counts an underflow, no bypass) and the push is stored; level becomes 1.
- pwm_out register: pwm_out <= enable & (counter < duty), using the counter and duty values before this cycle's update.
  - duty=0 gives a constantly low output.
  - duty=2^WIDTH-1 gives high for 2^WIDTH-1 of every 2^WIDTH cycles.
  - A newly loaded duty applies from counter=0 of the next period.
- Latency: a sample pushed into an empty FIFO appears on pwm_out in the period starting after the next wrap. The first high cycle is 1 cycle after counter=0 (registered output).
- flush: has priority over push and pop in the same cycle.
  - FIFO emptied, duty=MIDSCALE.
  - Counter is not reset.
  - Counters are not affected; no underflow is counted that cycle.
- clear_counts: zeroes both counters. It has priority over an increment in the same cycle.
- Saturation: both counters stop at 0xFFFF.
- enable deassert mid-period:
  - pwm_out goes low the next cycle and the counter returns to 0.
  - The FIFO keeps accepting pushes (and reporting overflow).
  - No pops and no underflows occur while disabled.
- enable reassert: the counter starts from 0 and the current duty is used for the first period.
- Reset mid-operation: asynchronous clear of all state. In-flight samples are lost.

Test Plan:
- Reset, enable=1, no input -> pwm_out high exactly 2048 of each 4096 cycles; underflow_count=1 after first wrap, 3 after third.
- Push 0x000, 0xFFF, 0x400 before first wrap -> consecutive periods give 0, 4095, 1024 high cycles. sample_tick pulses at each of 3 wraps, then underflow_count starts incrementing and duty holds 0x400.
- Push 10 samples back-to-back with enable=0 -> fifo_level=8, overflow_count=2. Enable -> the first 8 samples play in order.
- Full FIFO, in_valid on the wrap cycle -> sample accepted, fifo_level stays 8, overflow_count unchanged.
- Empty FIFO, push on the wrap cycle -> underflow_count+1, fifo_level=1, sample plays the following period.
- Force both counters to 0xFFFF -> they hold 0xFFFF. clear_counts coincident with an increment -> 0.
- flush with 5 queued samples mid-period -> fifo_level=0, next period 2048 high cycles. Async rst mid-period -> pwm_out=0 immediately.
